// File: rtl/axis_word_packetizer.sv
// Packs raw valid/ready producer words into AXI4-Stream frames with TLAST.
// A word waits in a hold register until its successor is visible or its last status is known.
module axis_word_packetizer #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAME_LEN      = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic [15:0]                   frames_sent,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(FRAME_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  flush_pending_q, flush_pending_d;
    logic [15:0]           frames_q, frames_d;

    logic [AW:0]           level;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  accept;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  at_last_beat;
    logic                  timeout_hit;
    logic                  frame_open;

    assign level        = wr_ptr_q - rd_ptr_q;
    assign fifo_empty   = (level == '0);
    assign fifo_full    = (level == DEPTH_L);
    assign accept       = in_valid && !fifo_full && !ARESET;
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign at_last_beat = (beat_cnt_q == LAST_BEAT);
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (tcnt_q >= TO_LIMIT);
    assign frame_open   = (beat_cnt_q != '0) || (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        tdata_d         = tdata_q;
        tlast_d         = tlast_q;
        beat_cnt_d      = beat_cnt_q;
        tcnt_d          = '0;
        frames_d        = frames_q;
        pop             = 1'b0;
        flush_pending_d = flush_pending_q;
        if (flush && frame_open) begin
            flush_pending_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (at_last_beat || !fifo_empty || flush_pending_q || timeout_hit) begin
                    // A non-final beat is only presented once its successor is already queued.
                    state_d = S_PRESENT;
                    tdata_d = hold_q;
                    tlast_d = at_last_beat || fifo_empty;
                end else if (!accept && (TIMEOUT_CYCLES != 0)) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_PRESENT: begin
                if (M_AXIS_TREADY) begin
                    beat_cnt_d = tlast_q ? '0 : beat_cnt_q + BW'(1);
                    if (tlast_q) begin
                        frames_d        = frames_q + 16'd1;
                        flush_pending_d = 1'b0;
                    end
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = head;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + (AW + 1)'(accept);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            state_q         <= S_IDLE;
            hold_q          <= '0;
            tdata_q         <= '0;
            tlast_q         <= 1'b0;
            beat_cnt_q      <= '0;
            tcnt_q          <= '0;
            flush_pending_q <= 1'b0;
            frames_q        <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            state_q         <= state_d;
            hold_q          <= hold_d;
            tdata_q         <= tdata_d;
            tlast_q         <= tlast_d;
            beat_cnt_q      <= beat_cnt_d;
            tcnt_q          <= tcnt_d;
            flush_pending_q <= flush_pending_d;
            frames_q        <= frames_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge ACLK) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign in_ready      = !ARESET && !fifo_full;
    assign M_AXIS_TVALID = !ARESET && (state_q == S_PRESENT);
    assign M_AXIS_TLAST  = !ARESET && (state_q == S_PRESENT) && tlast_q;
    assign M_AXIS_TDATA  = ARESET ? '0 : tdata_q;
    assign frames_sent   = ARESET ? '0 : frames_q;
    assign fifo_level    = ARESET ? '0 : level;

endmodule

// File: tb/tb_axis_word_packetizer.sv
// Bench for axis_word_packetizer: frame table, timing corner sequences and randomized traffic
// scored against per-word TLAST rules (FRAME_LEN=4, FIFO_DEPTH=8, TIMEOUT_CYCLES=16).
module tb_axis_word_packetizer;

    localparam int DW = 32;
    localparam int FL = 4;
    localparam int FD = 8;
    localparam int TO = 16;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;
    logic [15:0]   frames_sent;
    logic [3:0]    fifo_level;

    axis_word_packetizer #(
        .DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TLAST(M_AXIS_TLAST), .frames_sent(frames_sent), .fifo_level(fifo_level)
    );

    // Clock and cycle counter
    always #5 ACLK = ~ACLK;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [DW:0] exp_q[$];
    int hs_cnt  = 0;
    int hs_cyc  = 0;
    int acc_cyc = 0;
    logic [DW:0] mon_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Scoreboard: every stream handshake must match the head of exp_q ({tlast, tdata}).
    always @(negedge ACLK) begin
        if (in_valid && in_ready) acc_cyc = cyc;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            hs_cnt++;
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got tdata=0x%0h tlast=%0d, none expected",
                         M_AXIS_TDATA, M_AXIS_TLAST);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat", {31'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {31'd0, mon_e});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge ACLK);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) fail_now("send_word");
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget && hs_cnt < target; i++) tick();
        if (hs_cnt < target) fail_now("wait_hs");
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            fail_now("drain");
            exp_q.delete();
        end
        repeat (25) tick();
    endtask

    typedef struct {
        int          n;
        logic [31:0] base;
        bit          do_flush;
        logic [15:0] last_mask;
        int          frames;
    } vec_t;

    vec_t        tbl[7];
    int          exp_frames;
    int          k, acc, n, t1, t2, base, mism;
    bit          a;
    logic [31:0] d;
    logic [31:0] rw[$];
    logic [31:0] bw[12];

    initial begin
        tbl[0] = '{8, 32'h01, 1'b0, 16'h0088, 2};
        tbl[1] = '{0, 32'h00, 1'b1, 16'h0000, 0};
        tbl[2] = '{3, 32'h11, 1'b1, 16'h0004, 1};
        tbl[3] = '{2, 32'h21, 1'b0, 16'h0002, 1};
        tbl[4] = '{5, 32'h31, 1'b1, 16'h0018, 2};
        tbl[5] = '{1, 32'h41, 1'b1, 16'h0001, 1};
        tbl[6] = '{4, 32'h51, 1'b0, 16'h0008, 1};

        // Reset: outputs held at zero even with inputs active
        ARESET        = 1'b1;
        in_valid      = 1'b1;
        in_data       = 32'hFFFF_FFFF;
        flush         = 1'b1;
        M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        @(negedge ACLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_tvalid", M_AXIS_TVALID, 0);
        check("rst_tlast", M_AXIS_TLAST, 0);
        check("rst_tdata", M_AXIS_TDATA, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_level", fifo_level, 0);
        tick();
        ARESET   = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge ACLK);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_tvalid", M_AXIS_TVALID, 0);
        tick();
        exp_frames = 0;

        // Frame table: words, optional flush, expected TLAST pattern and frame count
        for (int r = 0; r < 7; r++) begin
            for (int j = 0; j < tbl[r].n; j++) begin
                d = tbl[r].base * 32'(j + 1);
                push_exp(d, tbl[r].last_mask[j]);
            end
            for (int j = 0; j < tbl[r].n; j++) begin
                d = tbl[r].base * 32'(j + 1);
                send_word(d);
            end
            if (tbl[r].do_flush) pulse_flush();
            wait_drain(80);
            exp_frames += tbl[r].frames;
            check("frames_row", frames_sent, exp_frames);
            check("level_row", fifo_level, 0);
        end

        // Timeout close: 0xB presented 16 idle HOLD cycles plus one after entering HOLD
        base = hs_cnt;
        push_exp(32'hA, 1'b0);
        push_exp(32'hB, 1'b1);
        send_word(32'hA);
        send_word(32'hB);
        wait_hs(base + 1, 50);
        t1 = hs_cyc;
        wait_hs(base + 2, 80);
        t2 = hs_cyc;
        check("timeout_gap", t2 - t1, 1 + TO + 1);
        wait_drain(40);
        exp_frames += 1;
        check("frames_timeout", frames_sent, exp_frames);

        // Backpressure: FIFO plus hold register absorb exactly FD+1 words
        M_AXIS_TREADY = 1'b0;
        for (int j = 0; j < 12; j++) bw[j] = 32'hB000_0000 + 32'(j);
        k   = 0;
        acc = 0;
        for (int cy = 0; cy < 30; cy++) begin
            if (k < 12) begin
                in_valid = 1'b1;
                in_data  = bw[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge ACLK);
            a = in_valid && in_ready;
            tick();
            if (a) begin
                k++;
                acc++;
            end
        end
        @(negedge ACLK);
        check("bp_accepted", acc, FD + 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_level", fifo_level, FD);
        check("bp_tvalid", M_AXIS_TVALID, 1);
        mism = 0;
        for (int cy = 0; cy < 20; cy++) begin
            @(negedge ACLK);
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== bw[0] || M_AXIS_TLAST !== 1'b0) mism++;
        end
        check("bp_stall_stable", mism, 0);
        in_valid = 1'b0;
        for (int j = 0; j < FD + 1; j++) push_exp(bw[j], (j % FL == FL - 1) || (j == FD));
        tick();
        M_AXIS_TREADY = 1'b1;
        wait_drain(100);
        exp_frames += 3;
        check("frames_bp", frames_sent, exp_frames);

        // Flush while the 4th word sits in HOLD, then a lone word must wait for the timeout
        base = hs_cnt;
        for (int j = 0; j < 4; j++) push_exp(32'hC1 + 32'(j), j == 3);
        push_exp(32'hC5, 1'b1);
        for (int j = 0; j < 4; j++) send_word(32'hC1 + 32'(j));
        wait_hs(base + 3, 50);
        pulse_flush();
        wait_hs(base + 4, 50);
        tick();
        send_word(32'hC5);
        wait_hs(base + 5, 80);
        check("stale_flush_gap", hs_cyc - acc_cyc, 2 + TO + 1);
        wait_drain(40);
        exp_frames += 2;
        check("frames_simul", frames_sent, exp_frames);

        // Randomized traffic: frames of FL beats, the final partial frame closed by timeout
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(10, 30);
            rw.delete();
            for (int j = 0; j < n; j++) begin
                rw.push_back($urandom);
                push_exp(rw[j], (j % FL == FL - 1) || (j == n - 1));
            end
            k        = 0;
            in_valid = 1'b0;
            for (int cy = 0; cy < 3000 && k < n; cy++) begin
                M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    in_data  = rw[k];
                    in_valid = 1'b1;
                end
                @(negedge ACLK);
                a = in_valid && in_ready;
                tick();
                if (a) begin
                    k++;
                    in_valid = 1'b0;
                end
            end
            in_valid      = 1'b0;
            M_AXIS_TREADY = 1'b1;
            if (k < n) fail_now("rand_send");
            wait_drain(300);
            exp_frames += (n + FL - 1) / FL;
            check("frames_rand", frames_sent, exp_frames);
        end

        // Reset mid-frame drops the partial frame
        base = hs_cnt;
        for (int j = 0; j < 3; j++) push_exp(32'hD1 + 32'(j), 1'b0);
        for (int j = 0; j < 3; j++) send_word(32'hD1 + 32'(j));
        wait_hs(base + 2, 50);
        ARESET = 1'b1;
        exp_q.delete();
        @(negedge ACLK);
        check("mid_rst_tvalid", M_AXIS_TVALID, 0);
        check("mid_rst_frames", frames_sent, 0);
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        check("after_rst_tvalid", M_AXIS_TVALID, 0);
        check("after_rst_frames", frames_sent, 0);
        check("after_rst_level", fifo_level, 0);
        tick();
        exp_frames = 0;
        for (int j = 0; j < 4; j++) push_exp(32'hE1 + 32'(j), j == 3);
        for (int j = 0; j < 4; j++) send_word(32'hE1 + 32'(j));
        wait_drain(60);
        exp_frames += 1;
        check("frames_after_rst", frames_sent, exp_frames);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
